mdl_req_sequencer: RTL and testbench

- Sits directly upstream of the MDL accounting unit (MAU).
- Accepts MDL cost requests from the CPU pipeline over a valid/ready interface and buffers them in a small FIFO.
- Issues them one at a time to the MAU over its 4-phase req/ack handshake.
- Returns each request's cost, error flag and running μ total to the pipeline through a one-entry response register.

---
 rtl/thiele_mau_pkg.sv | 19 +
 rtl/mdl_req_fifo.sv | 69 ++++++
 rtl/mdl_req_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_mdl_req_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thiele_mau_pkg.sv
// Shared types and constants for the MDL request path into the MAU.
package thiele_mau_pkg;

    localparam logic [31:0] MDL_COST_INF = 32'hFFFF_FFFF;
    localparam int unsigned ID_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [ID_W_DEFAULT-1:0] id;
        logic [31:0]             size;
        logic                    consistent;
    } mdl_req_t;

endpackage

// File: rtl/mdl_req_fifo.sv
// Synchronous FIFO for pending MDL requests; a push on full is accepted only alongside a pop.
module mdl_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 39
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth: pointers wrap by natural overflow.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mdl_req_sequencer.sv
// Queues MDL cost requests and issues them one at a time over the MAU 4-phase req/ack handshake.
module mdl_req_sequencer
    import thiele_mau_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ID_W    = ID_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ID_W-1:0]         in_module_id,
    input  logic [31:0]             in_module_size,
    input  logic                    in_consistent,
    output logic                    mdl_req,
    output logic [ID_W-1:0]         module_id,
    output logic [31:0]             module_size,
    output logic                    module_consistent,
    input  logic                    mdl_ack,
    input  logic [31:0]             mdl_cost,
    input  logic [31:0]             total_mu,
    input  logic                    mau_error,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_module_id,
    output logic [31:0]             resp_cost,
    output logic [31:0]             resp_total_mu,
    output logic                    resp_err,
    output logic                    resp_timeout,
    output logic [$clog2(DEPTH):0]  pending,
    output logic                    timeout_sticky
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam int unsigned EW    = ID_W + 33;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mdl_req_q, mdl_req_d;
    logic [ID_W-1:0]  module_id_q, module_id_d;
    logic [31:0]      module_size_q, module_size_d;
    logic             module_consistent_q, module_consistent_d;
    logic             resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]  resp_module_id_q, resp_module_id_d;
    logic [31:0]      resp_cost_q, resp_cost_d;
    logic [31:0]      resp_total_mu_q, resp_total_mu_d;
    logic             resp_err_q, resp_err_d;
    logic             resp_timeout_q, resp_timeout_d;
    logic             timeout_sticky_q, timeout_sticky_d;

    logic             fifo_full, fifo_empty, pop;
    logic [EW-1:0]    head;

    mdl_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (in_valid && in_ready),
        .wdata_i ({in_module_id, in_module_size, in_consistent}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (pending)
    );

    assign in_ready = !fifo_full;

    // Only issue once the response slot is free (or being freed) and the MAU has returned to zero.
    assign pop = (state_q == IDLE) && !fifo_empty && !mdl_ack &&
                 (!resp_valid_q || resp_ready);

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        mdl_req_d           = mdl_req_q;
        module_id_d         = module_id_q;
        module_size_d       = module_size_q;
        module_consistent_d = module_consistent_q;
        resp_valid_d        = resp_valid_q;
        resp_module_id_d    = resp_module_id_q;
        resp_cost_d         = resp_cost_q;
        resp_total_mu_d     = resp_total_mu_q;
        resp_err_d          = resp_err_q;
        resp_timeout_d      = resp_timeout_q;
        timeout_sticky_d    = timeout_sticky_q;

        if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    {module_id_d, module_size_d, module_consistent_d} = head;
                    mdl_req_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (mdl_ack) begin
                    resp_valid_d     = 1'b1;
                    resp_module_id_d = module_id_q;
                    resp_cost_d      = mdl_cost;
                    resp_total_mu_d  = total_mu;
                    resp_err_d       = mau_error;
                    resp_timeout_d   = 1'b0;
                    mdl_req_d        = 1'b0;
                    state_d          = DROP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    resp_valid_d     = 1'b1;
                    resp_module_id_d = module_id_q;
                    resp_cost_d      = MDL_COST_INF;
                    resp_total_mu_d  = total_mu;
                    resp_err_d       = 1'b1;
                    resp_timeout_d   = 1'b1;
                    timeout_sticky_d = 1'b1;
                    mdl_req_d        = 1'b0;
                    state_d          = DROP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DROP: begin
                if (!mdl_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                mdl_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= IDLE;
            cnt_q               <= '0;
            mdl_req_q           <= 1'b0;
            module_id_q         <= '0;
            module_size_q       <= '0;
            module_consistent_q <= 1'b0;
            resp_valid_q        <= 1'b0;
            resp_module_id_q    <= '0;
            resp_cost_q         <= '0;
            resp_total_mu_q     <= '0;
            resp_err_q          <= 1'b0;
            resp_timeout_q      <= 1'b0;
            timeout_sticky_q    <= 1'b0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            mdl_req_q           <= mdl_req_d;
            module_id_q         <= module_id_d;
            module_size_q       <= module_size_d;
            module_consistent_q <= module_consistent_d;
            resp_valid_q        <= resp_valid_d;
            resp_module_id_q    <= resp_module_id_d;
            resp_cost_q         <= resp_cost_d;
            resp_total_mu_q     <= resp_total_mu_d;
            resp_err_q          <= resp_err_d;
            resp_timeout_q      <= resp_timeout_d;
            timeout_sticky_q    <= timeout_sticky_d;
        end
    end

    assign mdl_req           = mdl_req_q;
    assign module_id         = module_id_q;
    assign module_size       = module_size_q;
    assign module_consistent = module_consistent_q;
    assign resp_valid        = resp_valid_q;
    assign resp_module_id    = resp_module_id_q;
    assign resp_cost         = resp_cost_q;
    assign resp_total_mu     = resp_total_mu_q;
    assign resp_err          = resp_err_q;
    assign resp_timeout      = resp_timeout_q;
    assign timeout_sticky    = timeout_sticky_q;

endmodule

// File: tb/tb_mdl_req_sequencer.sv
// Directed bench for mdl_req_sequencer: a cycle table for one transaction plus handshake corner cases.
module tb_mdl_req_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_module_id;
    logic [31:0] in_module_size;
    logic        in_consistent;
    logic        mdl_req;
    logic [5:0]  module_id;
    logic [31:0] module_size;
    logic        module_consistent;
    logic        mdl_ack;
    logic [31:0] mdl_cost;
    logic [31:0] total_mu;
    logic        mau_error;
    logic        resp_valid;
    logic        resp_ready;
    logic [5:0]  resp_module_id;
    logic [31:0] resp_cost;
    logic [31:0] resp_total_mu;
    logic        resp_err;
    logic        resp_timeout;
    logic [2:0]  pending;
    logic        timeout_sticky;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mdl_req_sequencer #(
        .DEPTH   (4),
        .TIMEOUT (16),
        .ID_W    (6)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_module_id      (in_module_id),
        .in_module_size    (in_module_size),
        .in_consistent     (in_consistent),
        .mdl_req           (mdl_req),
        .module_id         (module_id),
        .module_size       (module_size),
        .module_consistent (module_consistent),
        .mdl_ack           (mdl_ack),
        .mdl_cost          (mdl_cost),
        .total_mu          (total_mu),
        .mau_error         (mau_error),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_module_id    (resp_module_id),
        .resp_cost         (resp_cost),
        .resp_total_mu     (resp_total_mu),
        .resp_err          (resp_err),
        .resp_timeout      (resp_timeout),
        .pending           (pending),
        .timeout_sticky    (timeout_sticky)
    );

    typedef struct {
        logic        in_valid;
        logic [5:0]  in_id;
        logic [31:0] in_size;
        logic        in_cons;
        logic        ack;
        logic [31:0] cost;
        logic [31:0] tmu;
        logic        exp_req;
        logic        exp_rvalid;
        logic [2:0]  exp_pending;
        logic        exp_in_ready;
        logic [5:0]  exp_id;
        logic [31:0] exp_size;
        logic [31:0] exp_cost;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (mdl_req) ok = 1'b1;
            else step();
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no mdl_req expected mdl_req within 60 cycles", name);
        end
    endtask

    task automatic push(input logic [5:0] id, input logic [31:0] size, input logic cons);
        bit ok = 1'b0;
        in_valid       = 1'b1;
        in_module_id   = id;
        in_module_size = size;
        in_consistent  = cons;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            else step();
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_ready: got in_ready=0 expected in_ready=1 within 60 cycles");
        end
        step();
        in_valid = 1'b0;
    endtask

    // Acts as the MAU for one request; assumes resp_ready=1 so the response is consumed at once.
    task automatic serve(input logic [5:0] id, input logic [31:0] cost, input logic [31:0] tmu,
                         input logic merr, input int hold);
        bit ok;
        wait_req("serve_wait", ok);
        if (ok) begin
            check("serve_id", 64'(module_id), 64'(id));
            mdl_ack   = 1'b1;
            mdl_cost  = cost;
            total_mu  = tmu;
            mau_error = merr;
            step();
            mdl_cost  = 32'hDEAD_BEEF;
            mau_error = 1'b0;
            check("serve_req_low", 64'(mdl_req), 64'd0);
            check("serve_rvalid", 64'(resp_valid), 64'd1);
            check("serve_rid", 64'(resp_module_id), 64'(id));
            check("serve_cost", 64'(resp_cost), 64'(cost));
            check("serve_tmu", 64'(resp_total_mu), 64'(tmu));
            check("serve_err", 64'(resp_err), 64'(merr));
            check("serve_tmo", 64'(resp_timeout), 64'd0);
            for (int h = 0; h < hold; h++) begin
                step();
                check("drop_hold_req", 64'(mdl_req), 64'd0);
            end
            mdl_ack = 1'b0;
            step();
        end
    endtask

    initial begin
        bit ok;
        int cnt;

        //              iv  id     size      c   ack cost    tmu    req rv pend ir id     size      cost
        vecs[0] = '{1'b1, 6'd3, 32'd1000, 1'b1, 1'b0, 32'd0,  32'd0,  1'b0, 1'b0, 3'd0, 1'b1, 6'd0, 32'd0,    32'd0};
        vecs[1] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 32'd0,  32'd0,  1'b0, 1'b0, 3'd1, 1'b1, 6'd0, 32'd0,    32'd0};
        vecs[2] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 32'd0,  32'd0,  1'b1, 1'b0, 3'd0, 1'b1, 6'd3, 32'd1000, 32'd0};
        vecs[3] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 32'd0,  32'd0,  1'b1, 1'b0, 3'd0, 1'b1, 6'd3, 32'd1000, 32'd0};
        vecs[4] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b1, 32'd10, 32'd10, 1'b1, 1'b0, 3'd0, 1'b1, 6'd3, 32'd1000, 32'd0};
        vecs[5] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 32'd0,  32'd0,  1'b0, 1'b1, 3'd0, 1'b1, 6'd3, 32'd0,    32'd10};
        vecs[6] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 32'd0,  32'd0,  1'b0, 1'b0, 3'd0, 1'b1, 6'd0, 32'd0,    32'd0};

        rst = 1'b1; in_valid = 1'b0; in_module_id = '0; in_module_size = '0; in_consistent = 1'b0;
        mdl_ack = 1'b0; mdl_cost = '0; total_mu = '0; mau_error = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        check("rst_req", 64'(mdl_req), 64'd0);
        check("rst_rvalid", 64'(resp_valid), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_sticky", 64'(timeout_sticky), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Single request, cycle by cycle
        for (int k = 0; k < 7; k++) begin
            check($sformatf("t1_req[%0d]", k), 64'(mdl_req), 64'(vecs[k].exp_req));
            check($sformatf("t1_rvalid[%0d]", k), 64'(resp_valid), 64'(vecs[k].exp_rvalid));
            check($sformatf("t1_pending[%0d]", k), 64'(pending), 64'(vecs[k].exp_pending));
            check($sformatf("t1_in_ready[%0d]", k), 64'(in_ready), 64'(vecs[k].exp_in_ready));
            if (vecs[k].exp_req) begin
                check($sformatf("t1_id[%0d]", k), 64'(module_id), 64'(vecs[k].exp_id));
                check($sformatf("t1_size[%0d]", k), 64'(module_size), 64'(vecs[k].exp_size));
                check($sformatf("t1_cons[%0d]", k), 64'(module_consistent), 64'd1);
            end
            if (vecs[k].exp_rvalid) begin
                check($sformatf("t1_rid[%0d]", k), 64'(resp_module_id), 64'(vecs[k].exp_id));
                check($sformatf("t1_rcost[%0d]", k), 64'(resp_cost), 64'(vecs[k].exp_cost));
                check($sformatf("t1_rtmu[%0d]", k), 64'(resp_total_mu), 64'(vecs[k].exp_cost));
                check($sformatf("t1_rerr[%0d]", k), 64'(resp_err), 64'd0);
            end
            in_valid       = vecs[k].in_valid;
            in_module_id   = vecs[k].in_id;
            in_module_size = vecs[k].in_size;
            in_consistent  = vecs[k].in_cons;
            mdl_ack        = vecs[k].ack;
            mdl_cost       = vecs[k].cost;
            total_mu       = vecs[k].tmu;
            step();
        end

        // Fill the FIFO while a stuck-high ack blocks issue
        mdl_ack = 1'b1;
        for (int i = 0; i < 4; i++) push(6'(10 + i), 32'(100 + i), 1'b0);
        check("full_pending", 64'(pending), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_module_id = 6'd14; in_module_size = 32'd104; in_consistent = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("full_hold_pending", 64'(pending), 64'd4);
            check("full_hold_req", 64'(mdl_req), 64'd0);
        end
        mdl_ack = 1'b0;
        step();
        check("pop_pending", 64'(pending), 64'd3);
        check("pop_in_ready", 64'(in_ready), 64'd1);
        check("pop_req", 64'(mdl_req), 64'd1);
        step();
        in_valid = 1'b0;
        check("refill_pending", 64'(pending), 64'd4);
        for (int i = 0; i < 5; i++) serve(6'(10 + i), 32'(20 + i), 32'(200 + i), 1'b0, 0);
        check("drain_pending", 64'(pending), 64'd0);

        // MAU never acks
        total_mu = 32'd77;
        push(6'd20, 32'd5, 1'b1);
        push(6'd21, 32'd6, 1'b0);
        wait_req("tmo_wait", ok);
        cnt = 0;
        while (mdl_req && cnt < 100) begin
            cnt++;
            step();
        end
        check("tmo_req_cycles", 64'(cnt), 64'd16);
        check("tmo_rvalid", 64'(resp_valid), 64'd1);
        check("tmo_rid", 64'(resp_module_id), 64'd20);
        check("tmo_flag", 64'(resp_timeout), 64'd1);
        check("tmo_err", 64'(resp_err), 64'd1);
        check("tmo_cost", 64'(resp_cost), 64'hFFFF_FFFF);
        check("tmo_tmu", 64'(resp_total_mu), 64'd77);
        check("tmo_sticky", 64'(timeout_sticky), 64'd1);
        serve(6'd21, 32'd7, 32'd84, 1'b0, 0);

        // Response back-pressure
        resp_ready = 1'b0;
        push(6'd30, 32'd1, 1'b0);
        push(6'd31, 32'd2, 1'b0);
        wait_req("bp_wait", ok);
        check("bp_id0", 64'(module_id), 64'd30);
        mdl_ack = 1'b1; mdl_cost = 32'd3; total_mu = 32'd90;
        step();
        mdl_ack = 1'b0; mdl_cost = 32'd0;
        check("bp_rvalid", 64'(resp_valid), 64'd1);
        check("bp_rid", 64'(resp_module_id), 64'd30);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_req", 64'(mdl_req), 64'd0);
            check("bp_hold_rvalid", 64'(resp_valid), 64'd1);
            check("bp_hold_cost", 64'(resp_cost), 64'd3);
            check("bp_hold_pending", 64'(pending), 64'd1);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("bp_release_req", 64'(mdl_req), 64'd1);
        check("bp_release_id", 64'(module_id), 64'd31);
        check("bp_release_rvalid", 64'(resp_valid), 64'd0);
        resp_ready = 1'b1;
        serve(6'd31, 32'd4, 32'd94, 1'b0, 0);

        // Ack held after req falls, with an MAU error
        push(6'd40, 32'd8, 1'b1);
        push(6'd41, 32'd9, 1'b0);
        serve(6'd40, 32'd5, 32'd99, 1'b1, 3);
        serve(6'd41, 32'd6, 32'd105, 1'b0, 0);

        // Reset while a request is outstanding
        push(6'd50, 32'd11, 1'b0);
        push(6'd51, 32'd12, 1'b0);
        check("prerst_req", 64'(mdl_req), 64'd1);
        check("prerst_pending", 64'(pending), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_req", 64'(mdl_req), 64'd0);
        check("midrst_pending", 64'(pending), 64'd0);
        check("midrst_rvalid", 64'(resp_valid), 64'd0);
        check("midrst_sticky", 64'(timeout_sticky), 64'd0);
        step();
        step();
        check("postrst_idle_req", 64'(mdl_req), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1);
    end

endmodule
